// File: rtl/spi_master_arbiter_pkg.sv
// Shared types and helpers for the spi_master round-robin arbiter.
// Also hosts constants reused by future arbiters.
package spi_master_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    RESPOND
  } state_t;

  localparam logic ERR_NONE          = 1'b0;
  localparam logic ERR_START_TIMEOUT = 1'b1;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_REQUESTERS = 4;
  localparam int ID_WIDTH = id_width(DEFAULT_REQUESTERS);

endpackage

// File: rtl/spi_master_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request after pointer,
// wrapping, as one-hot grant plus index.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  int j;

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(pointer) + i) % N;
      if (!any && request[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        index    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one spi_master between several requesters,
// single-word commands with start timeout.
module spi_master_arbiter
  import spi_master_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDRESS_WIDTH  = 15,
  parameter int START_TIMEOUT  = 64,
  localparam int IW = id_width(NUM_REQUESTERS)
) (
  input  logic clock,
  input  logic reset,
  input  logic [NUM_REQUESTERS-1:0] request_valid,
  output logic [NUM_REQUESTERS-1:0] request_ready,
  input  logic [NUM_REQUESTERS-1:0] request_read_write,
  input  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0] request_address,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] request_data,
  output logic [NUM_REQUESTERS-1:0] response_valid,
  output logic [DATA_WIDTH-1:0] response_data,
  output logic response_error,
  output logic spi_enable,
  output logic spi_read_write,
  output logic [ADDRESS_WIDTH-1:0] spi_address,
  output logic [DATA_WIDTH-1:0] spi_data,
  input  logic spi_busy,
  input  logic [DATA_WIDTH-1:0] spi_read_data,
  output logic [IW-1:0] grant_id,
  output logic active
);

  localparam int TW = $clog2(START_TIMEOUT + 1);

  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, gid_n;
  logic [TW-1:0] cnt, cnt_n;
  logic en_n, rw_n, err_n, act_n;
  logic [ADDRESS_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] data_n, rdata_n;
  logic [NUM_REQUESTERS-1:0] pick_grant;
  logic [IW-1:0] pick_idx;
  logic pick_any;

  rr_priority_picker #(
    .N  (NUM_REQUESTERS),
    .IW (IW)
  ) u_pick (
    .request (request_valid),
    .pointer (ptr),
    .grant   (pick_grant),
    .index   (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gid_n   = grant_id;
    cnt_n   = cnt;
    en_n    = spi_enable;
    rw_n    = spi_read_write;
    addr_n  = spi_address;
    data_n  = spi_data;
    rdata_n = response_data;
    err_n   = response_error;
    act_n   = active;
    request_ready  = '0;
    response_valid = '0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (!spi_busy && pick_any) begin
            request_ready = pick_grant;
            ptr_n   = pick_idx;
            gid_n   = pick_idx;
            rw_n    = request_read_write[pick_idx];
            addr_n  = request_address[int'(pick_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            data_n  = request_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            en_n    = 1'b1;
            cnt_n   = '0;
            err_n   = ERR_NONE;
            act_n   = 1'b1;
            state_n = LAUNCH;
          end
        end
        LAUNCH: begin
          if (spi_busy) begin
            en_n    = 1'b0;
            state_n = WAIT_DONE;
          end else if (cnt == TW'(START_TIMEOUT - 1)) begin
            en_n    = 1'b0;
            err_n   = ERR_START_TIMEOUT;
            rdata_n = '0;
            state_n = RESPOND;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!spi_busy) begin
            rdata_n = spi_read_write ? spi_read_data : '0;
            err_n   = ERR_NONE;
            state_n = RESPOND;
          end
        end
        RESPOND: begin
          response_valid[grant_id] = 1'b1;
          act_n   = 1'b0;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= IW'(NUM_REQUESTERS - 1);
      grant_id       <= '0;
      cnt            <= '0;
      spi_enable     <= 1'b0;
      spi_read_write <= 1'b0;
      spi_address    <= '0;
      spi_data       <= '0;
      response_data  <= '0;
      response_error <= 1'b0;
      active         <= 1'b0;
    end else begin
      state          <= state_n;
      ptr            <= ptr_n;
      grant_id       <= gid_n;
      cnt            <= cnt_n;
      spi_enable     <= en_n;
      spi_read_write <= rw_n;
      spi_address    <= addr_n;
      spi_data       <= data_n;
      response_data  <= rdata_n;
      response_error <= err_n;
      active         <= act_n;
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against
// a transaction-level model with a behavioural SPI slave.
module tb_spi_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int TO = 64;
  localparam int IW = 2;

  localparam int P_IDLE = 0;
  localparam int P_LAUNCH = 1;
  localparam int P_SPI = 2;
  localparam int P_RESP = 3;

  logic clock = 1'b0;
  logic reset;
  logic [N-1:0] request_valid, request_ready, request_read_write;
  logic [N*AW-1:0] request_address;
  logic [N*DW-1:0] request_data;
  logic [N-1:0] response_valid;
  logic [DW-1:0] response_data;
  logic response_error;
  logic spi_enable, spi_read_write;
  logic [AW-1:0] spi_address;
  logic [DW-1:0] spi_data;
  logic spi_busy;
  logic [DW-1:0] spi_read_data;
  logic [IW-1:0] grant_id;
  logic active;

  logic slave_busy, stray_busy, slave_on, rd_force_en;
  logic [DW-1:0] rd_force;
  int slave_len_force;

  assign spi_busy = slave_busy | stray_busy;

  always #5 clock = ~clock;

  spi_master_arbiter #(
    .NUM_REQUESTERS (N),
    .DATA_WIDTH     (DW),
    .ADDRESS_WIDTH  (AW),
    .START_TIMEOUT  (TO)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .request_valid      (request_valid),
    .request_ready      (request_ready),
    .request_read_write (request_read_write),
    .request_address    (request_address),
    .request_data       (request_data),
    .response_valid     (response_valid),
    .response_data      (response_data),
    .response_error     (response_error),
    .spi_enable         (spi_enable),
    .spi_read_write     (spi_read_write),
    .spi_address        (spi_address),
    .spi_data           (spi_data),
    .spi_busy           (spi_busy),
    .spi_read_data      (spi_read_data),
    .grant_id           (grant_id),
    .active             (active)
  );

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // transaction-level model state, advanced once per cycle
  int ph = P_IDLE;
  int m_ptr = N - 1;
  int owner = 0;
  int n_launch = 0;
  logic m_rw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rdata;
  logic m_err;
  int cyc = 0, grant_cnt = 0, resp_cnt = 0, last_grant = -1;
  int last_resp_owner = -1, resp_cyc = 0, fall_cyc = 0;
  int en_run = 0, last_en_run = 0;
  logic [DW-1:0] last_resp_data;
  logic last_resp_err, prev_busy = 1'b0, zero_pending = 1'b0;
  logic [N-1:0] last_ready = '0;
  int grant_q[$];

  always @(negedge clock) begin
    logic [N-1:0] oh;
    int g, j;
    cyc++;
    if (zero_pending) begin
      zero_pending = 1'b0;
      chk("rst_enable", spi_enable, 0);
      chk("rst_rw", spi_read_write, 0);
      chk("rst_addr", spi_address, 0);
      chk("rst_data", spi_data, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_active", active, 0);
      chk("rst_rdata", response_data, 0);
      chk("rst_rerr", response_error, 0);
    end
    if (reset) begin
      chk("rst_ready", request_ready, 0);
      chk("rst_rvalid", response_valid, 0);
      m_ptr = N - 1;
      ph = P_IDLE;
      zero_pending = 1'b1;
    end else if (ph == P_IDLE) begin
      g = -1;
      oh = '0;
      if (!spi_busy)
        for (int d = 1; d <= N; d++) begin
          j = (m_ptr + d) % N;
          if (g < 0 && request_valid[j]) g = j;
        end
      if (g >= 0) oh[g] = 1'b1;
      chk("ready", request_ready, oh);
      chk("idle_enable", spi_enable, 0);
      chk("idle_rvalid", response_valid, 0);
      chk("idle_active", active, 0);
      if (g >= 0) begin
        owner = g;
        m_ptr = g;
        m_rw = request_read_write[g];
        m_addr = request_address[g*AW +: AW];
        m_data = request_data[g*DW +: DW];
        ph = P_LAUNCH;
        n_launch = 0;
        grant_cnt++;
        last_grant = g;
        grant_q.push_back(g);
      end
    end else begin
      oh = '0;
      oh[owner] = 1'b1;
      chk("busy_ready", request_ready, 0);
      chk("busy_active", active, 1);
      chk("gid", grant_id, owner);
      chk("spi_addr", spi_address, m_addr);
      chk("spi_data", spi_data, m_data);
      chk("spi_rw", spi_read_write, m_rw);
      if (ph == P_LAUNCH) begin
        chk("launch_enable", spi_enable, 1);
        chk("launch_rvalid", response_valid, 0);
        if (spi_busy) ph = P_SPI;
        else if (n_launch == TO - 1) begin
          ph = P_RESP;
          m_err = 1'b1;
          m_rdata = '0;
        end else n_launch++;
      end else if (ph == P_SPI) begin
        chk("spi_enable", spi_enable, 0);
        chk("spi_rvalid", response_valid, 0);
        if (!spi_busy) begin
          ph = P_RESP;
          m_err = 1'b0;
          m_rdata = m_rw ? spi_read_data : '0;
        end
      end else begin
        chk("resp_enable", spi_enable, 0);
        chk("resp_rvalid", response_valid, oh);
        chk("resp_data", response_data, m_rdata);
        chk("resp_err", response_error, m_err);
        resp_cnt++;
        resp_cyc = cyc;
        last_resp_owner = owner;
        last_resp_data = response_data;
        last_resp_err = response_error;
        ph = P_IDLE;
      end
    end
    if (prev_busy && !spi_busy) fall_cyc = cyc;
    prev_busy = spi_busy;
    if (spi_enable) en_run++;
    else if (en_run > 0) begin
      last_en_run = en_run;
      en_run = 0;
    end
    last_ready = request_ready;
  end

  // behavioural SPI slave: busy rises 1..3 cycles after enable
  initial begin
    int d, len;
    slave_busy = 1'b0;
    spi_read_data = '0;
    forever begin
      @(negedge clock);
      if (slave_on && spi_enable && !slave_busy) begin
        d = $urandom_range(0, 2);
        len = (slave_len_force > 0) ? slave_len_force : $urandom_range(1, 6);
        repeat (d) @(posedge clock);
        @(posedge clock);
        #1 slave_busy = 1'b1;
        repeat (len) @(posedge clock);
        #1 slave_busy = 1'b0;
        spi_read_data = rd_force_en ? rd_force : DW'($urandom);
      end
    end
  end

  task automatic issue(input int i, input logic rw,
                       input logic [AW-1:0] a, input logic [DW-1:0] dd);
    request_read_write[i] = rw;
    request_address[i*AW +: AW] = a;
    request_data[i*DW +: DW] = dd;
    request_valid[i] = 1'b1;
  endtask

  task automatic issue_rand(input int i);
    issue(i, 1'($urandom), AW'($urandom), DW'($urandom));
  endtask

  task automatic wait_grant(input int start, output int g);
    g = -1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clock);
      #1;
      if (grant_cnt > start) begin
        g = last_grant;
        return;
      end
    end
    n_total++;
    $display("FAIL wait_grant: no accept within 400 cycles");
  endtask

  task automatic wait_resp(input int start);
    for (int k = 0; k < 400; k++) begin
      @(posedge clock);
      #1;
      if (resp_cnt > start) return;
    end
    n_total++;
    $display("FAIL wait_resp: no response within 400 cycles");
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    int g, gs, rs, k;
    int exp_order[8];
    reset = 1'b1;
    request_valid = '0;
    request_read_write = '0;
    request_address = '0;
    request_data = '0;
    stray_busy = 1'b0;
    slave_on = 1'b1;
    rd_force_en = 1'b0;
    rd_force = '0;
    slave_len_force = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // single write from requester 2
    gs = grant_cnt;
    issue(2, 1'b0, 15'h1111, 16'hA5A5);
    wait_grant(gs, g);
    request_valid[2] = 1'b0;
    chk("t2_grant", g, 2);
    chk("t2_enable", spi_enable, 1);
    chk("t2_addr", spi_address, 15'h1111);
    chk("t2_data", spi_data, 16'hA5A5);
    rs = resp_cnt;
    wait_resp(rs);
    chk("t2_owner", last_resp_owner, 2);
    chk("t2_err", last_resp_err, 0);
    chk("t2_rdata", last_resp_data, 0);

    // single read from requester 0
    rd_force_en = 1'b1;
    rd_force = 16'h3C5A;
    gs = grant_cnt;
    issue(0, 1'b1, 15'h0042, 16'h0000);
    wait_grant(gs, g);
    request_valid[0] = 1'b0;
    chk("t3_grant", g, 0);
    rs = resp_cnt;
    wait_resp(rs);
    chk("t3_owner", last_resp_owner, 0);
    chk("t3_rdata", last_resp_data, 16'h3C5A);
    chk("t3_latency", resp_cyc - fall_cyc, 1);
    rd_force_en = 1'b0;

    // all requesters valid: strict rotation after reset
    do_reset(2);
    grant_q.delete();
    rs = resp_cnt;
    for (int i = 0; i < N; i++) issue_rand(i);
    for (int t = 0; t < 8; t++) begin
      gs = grant_cnt;
      wait_grant(gs, g);
      if (t < 7) issue_rand(g);
      else request_valid = '0;
    end
    for (k = 0; k < 400 && resp_cnt < rs + 8; k++) @(posedge clock);
    #1;
    chk("t4_resp_count", resp_cnt - rs, 8);
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk("t4_grant_count", grant_q.size(), 8);
    for (int t = 0; t < 8 && t < grant_q.size(); t++)
      chk("t4_order", grant_q[t], exp_order[t]);

    // start timeout: slave never answers
    slave_on = 1'b0;
    gs = grant_cnt;
    issue(1, 1'b1, 15'h0777, 16'h1234);
    wait_grant(gs, g);
    request_valid[1] = 1'b0;
    chk("t5_grant", g, 1);
    rs = resp_cnt;
    wait_resp(rs);
    chk("t5_err", last_resp_err, 1);
    chk("t5_rdata", last_resp_data, 0);
    chk("t5_enable_cycles", last_en_run, TO);
    slave_on = 1'b1;
    gs = grant_cnt;
    issue(3, 1'b0, 15'h0123, 16'h4321);
    wait_grant(gs, g);
    request_valid[3] = 1'b0;
    chk("t5_next_grant", g, 3);
    rs = resp_cnt;
    wait_resp(rs);
    chk("t5_next_err", last_resp_err, 0);

    // reset while waiting for busy to fall
    slave_len_force = 10;
    gs = grant_cnt;
    issue(0, 1'b1, 15'h0055, 16'h0000);
    wait_grant(gs, g);
    request_valid[0] = 1'b0;
    for (k = 0; k < 50 && ph != P_SPI; k++) begin
      @(posedge clock);
      #1;
    end
    chk("t6_in_wait", ph, P_SPI);
    rs = resp_cnt;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("t6_enable", spi_enable, 0);
    chk("t6_active", active, 0);
    gs = grant_cnt;
    issue(2, 1'b0, 15'h0202, 16'h2222);
    issue(0, 1'b0, 15'h0101, 16'h1111);
    wait_grant(gs, g);
    request_valid = '0;
    chk("t6_grant", g, 0);
    chk("t6_no_resp", resp_cnt - rs, 0);
    wait_resp(rs);
    slave_len_force = 0;

    // requester 1 withdraws before being granted
    stray_busy = 1'b1;
    gs = grant_cnt;
    issue(1, 1'b0, 15'h0011, 16'h0011);
    issue(3, 1'b0, 15'h0033, 16'h0033);
    repeat (3) @(posedge clock);
    #1;
    chk("t7_hold", grant_cnt - gs, 0);
    request_valid[1] = 1'b0;
    stray_busy = 1'b0;
    wait_grant(gs, g);
    request_valid[3] = 1'b0;
    chk("t7_grant", g, 3);
    rs = resp_cnt;
    wait_resp(rs);
    gs = grant_cnt;
    issue(0, 1'b0, 15'h0000, 16'h0000);
    issue(1, 1'b0, 15'h0001, 16'h0001);
    wait_grant(gs, g);
    request_valid = '0;
    chk("t7_next", g, 0);
    rs = resp_cnt;
    wait_resp(rs);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (last_ready[i]) begin
          if ($urandom_range(0, 1) == 1) issue_rand(i);
          else request_valid[i] = 1'b0;
        end else if (!request_valid[i]) begin
          if ($urandom_range(0, 5) == 0) issue_rand(i);
        end else if ($urandom_range(0, 49) == 0) begin
          request_valid[i] = 1'b0;
        end
      end
      stray_busy = ($urandom_range(0, 39) == 0);
    end
    request_valid = '0;
    stray_busy = 1'b0;
    for (k = 0; k < 400 && (ph != P_IDLE || slave_busy); k++) @(posedge clock);
    #1;
    chk("drain_idle", ph, P_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares a single spi_master instance between NUM_REQUESTERS independent command sources, using round-robin arbitration.
- Accepts one single-word command at a time (read or write, address, data), drives the spi_master enable/control inputs, and tracks busy to detect completion.
- Returns read data, or a timeout error, to the requester that owns the transaction.
- Sits between on-chip clients (sensor pollers, config loaders) and spi_master; burst mode is not used (burst_enable tied 0 at top level).

Parameters:
NUM_REQUESTERS, 4, number of requester ports (2..8)
DATA_WIDTH, 16, SPI data word width; matches spi_master
ADDRESS_WIDTH, 15, SPI address width; matches spi_master
START_TIMEOUT, 64, max cycles from enable assertion to busy rising before abort

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
request_valid  input  NUM_REQUESTERS  per-requester command valid
request_ready  output  NUM_REQUESTERS  per-requester command accept, one-hot, 1-cycle pulse
request_read_write  input  NUM_REQUESTERS  1=read, 0=write, per requester
request_address  input  NUM_REQUESTERS*ADDRESS_WIDTH  packed addresses, requester i at slice i
request_data  input  NUM_REQUESTERS*DATA_WIDTH  packed write data
response_valid  output  NUM_REQUESTERS  one-hot completion pulse, 1 cycle
response_data  output  DATA_WIDTH  captured read_data (0 for writes)
response_error  output  1  qualified by response_valid; 1=start timeout
spi_enable  output  1  to spi_master.enable
spi_read_write  output  1  to spi_master.read_write
spi_address  output  ADDRESS_WIDTH  to spi_master.address
spi_data  output  DATA_WIDTH  to spi_master.data
spi_busy  input  1  from spi_master.busy
spi_read_data  input  DATA_WIDTH  from spi_master.read_data
grant_id  output  clog2(NUM_REQUESTERS)  index of current/last owner (debug)
active  output  1  high from accept to response

Behaviour:
- Reset (synchronous, priority over everything): state=IDLE; all outputs 0; round-robin pointer=NUM_REQUESTERS-1, so requester 0 has first priority.
- IDLE:
  - If spi_busy=0 and any request_valid is set, grant the first set bit searching from pointer+1 with wrap.
  - In that cycle: request_ready[g]=1; latch read_write, address and data into output registers; pointer<=g; grant_id<=g; go to LAUNCH.
  - If spi_busy=1 in IDLE (stray activity), hold; no grant.
- LAUNCH:
  - spi_enable=1 from the cycle after accept; the timeout counter counts from 0.
  - On spi_busy=1: spi_enable<=0, go to WAIT_DONE.
  - On counter==START_TIMEOUT-1 with busy still low: spi_enable<=0, go to RESPOND with error=1.
- WAIT_DONE:
  - spi_busy high: hold.
  - spi_busy falls to 0: capture spi_read_data for reads (0 for writes), go to RESPOND.
  - No timeout in this state.
- RESPOND:
  - One cycle: response_valid[g]=1, response_data/response_error valid, active<=0.
  - Next state IDLE. A new grant is allowed in the following cycle, never in the RESPOND cycle itself.
- Latencies:
  - Accept to spi_enable: exactly 1 cycle.
  - busy fall to response_valid: exactly 1 cycle.
  - Minimum gap between consecutive accepts: 4 cycles plus SPI duration.
- spi_address, spi_data and spi_read_write stay stable from LAUNCH through RESPOND.
- request_valid may drop without being granted; there is no penalty and the pointer is unchanged.
- Requesters must hold command fields stable while request_valid=1 and ready=0.
- Simultaneous valid on all ports: grants rotate strictly 0,1,2,3,0,…; no requester waits more than NUM_REQUESTERS-1 transactions.
- Reset mid-transaction: FSM returns to IDLE and spi_enable drops. No response is issued; the in-flight requester must re-request. The arbiter ignores busy until it is low.

Decomposition:
- Package spi_master_arbiter_pkg holds:
  - state enum (IDLE, LAUNCH, WAIT_DONE, RESPOND)
  - localparam ID_WIDTH = clog2(NUM_REQUESTERS) helper
  - response error code constant
- Sub-module rr_priority_picker (combinational): request vector + pointer → one-hot grant + index. It is reusable by future arbiters.

Test Plan:
- Single write, requester 2, address 0x1111, data 0xA5A5: request_ready[2] one cycle; spi_enable the next cycle; spi_address=0x1111 through completion; response_valid[2]=1 with response_error=0 and response_data=0.
- Single read, requester 0: slave model returns 0x3C5A. response_data=0x3C5A exactly 1 cycle after busy falls.
- All four requesters valid continuously, 8 transactions: grant order 0,1,2,3,0,1,2,3; each response_valid one-hot matches its grant.
- Timeout: spi_busy forced 0, START_TIMEOUT=64. spi_enable is high 64 cycles then drops; response_valid pulses with response_error=1; the next request is accepted normally.
- Reset asserted during WAIT_DONE: next cycle all outputs 0, no response_valid. After reset release, requester 0 is granted first.
- Requester 1 drops valid before grant while requester 3 is valid: requester 3 is granted; the pointer then gives requester 0 priority next.
